inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one word-aligned read per fetch_start, captures the
// returned word into inst, pulses irwrite and advances pc; faults on misalignment or timeout.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic        irwrite,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             irwrite_q, irwrite_d;
  logic             busy_q, busy_d;
  logic             fetch_err_q, fetch_err_d;
  logic [31:0]      fetch_addr;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state, pc, instruction and timeout-counter logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cnt_d      = cnt_q;
    fetch_addr = pc_load ? pc_next : pc_q;
    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          pc_d    = fetch_addr;
          cnt_d   = '0;
          state_d = (fetch_addr[1:0] == 2'b00) ? REQ : ERR;
        end else if (pc_load) begin
          pc_d = pc_next;
        end
      end
      REQ: begin
        if (mem_ack) begin
          inst_d  = mem_rdata;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ERR;
        end
      end
      LOAD: begin
        pc_d    = pc_plus4;
        state_d = IDLE;
      end
      ERR: begin
        if (pc_load && (pc_next[1:0] == 2'b00)) begin
          pc_d    = pc_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q
    mem_req_d   = (state_d == REQ);
    irwrite_d   = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    fetch_err_d = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      irwrite_q   <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      irwrite_q   <= irwrite_d;
      busy_q      <= busy_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = pc_q;
  assign inst      = inst_q;
  assign irwrite   = irwrite_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign fetch_err = fetch_err_q;

endmodule
